// File: rtl/sdp_fifo32_ctrl_pkg.sv
// Shared constants and types for the 32-deep SDP FIFO controller.
package sdp_fifo32_ctrl_pkg;

  localparam int FIFO_ABITS = 5;
  localparam int FIFO_DEPTH = 32;
  localparam int LVL_W      = 6;
  localparam int LANE_W     = 6;

  typedef logic [FIFO_ABITS-1:0] ptr_t;
  typedef logic [LVL_W-1:0]      lvl_t;

  typedef struct packed {
    logic acc;   // write lands in RAM this edge
    logic load;  // head word moves RAM -> output register
    logic drop;  // write refused because the RAM is full
  } ctl_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/sdp_fifo32_ctrl_ram.sv
// One 32x6 simple-dual-port lane: synchronous write, asynchronous read.
module sdp_fifo32_ctrl_ram
  import sdp_fifo32_ctrl_pkg::*;
#(
  parameter int DELAY = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  ptr_t              waddr_i,
  input  logic [LANE_W-1:0] wdat_i,
  input  ptr_t              raddr_i,
  output logic [LANE_W-1:0] rdat_o
);

  logic [LANE_W-1:0] mem_q [FIFO_DEPTH];

  // DELAY only shapes the vendor primitive's simulation model; here writes are zero-delay.
  if (DELAY < 0) begin : g_neg_delay
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdat_i;
  end

  assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/sdp_fifo32_ctrl.sv
// 32-deep FIFO controller over WIDTH/6 RAM lanes with a registered FWFT output stage.
module sdp_fifo32_ctrl
  import sdp_fifo32_ctrl_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             full_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] dat_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int NUM_LANES = WIDTH / LANE_W;

  ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
  lvl_t             count_q, count_d, level_q, level_d;
  logic             full_q, full_d, ovf_q, ovf_d, valid_q, valid_d;
  logic [WIDTH-1:0] dat_q, dat_d, rd_word;
  ctl_t             ctl;

  logic [NUM_LANES-1:0][LANE_W-1:0] ram_rdat;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sdp_fifo32_ctrl_ram #(.DELAY(DELAY)) u_ram (
      .clk_i   (clk_i),
      .we_i    (ctl.acc),
      .waddr_i (wptr_q),
      .wdat_i  (dat_i[g*LANE_W +: LANE_W]),
      .raddr_i (rptr_q),
      .rdat_o  (ram_rdat[g])
    );
  end

  assign rd_word = ram_rdat;

  // full_q is the pre-edge state: a word leaving this cycle never frees a slot for a same-cycle write.
  always_comb begin
    ctl.acc  = wr_i & ~full_q & ~flush_i;
    ctl.drop = wr_i &  full_q & ~flush_i;
    ctl.load = (count_q != '0) & (~valid_q | ready_i) & ~flush_i;

    wptr_d  = ctl.acc  ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = ctl.load ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + lvl_t'(ctl.acc) - lvl_t'(ctl.load);
    ovf_d   = ovf_q | ctl.drop;
    dat_d   = ctl.load ? rd_word : dat_q;

    if (ctl.load)               valid_d = 1'b1;
    else if (valid_q & ready_i) valid_d = 1'b0;
    else                        valid_d = valid_q;

    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end

    full_d  = (count_d == lvl_t'(FIFO_DEPTH));
    level_d = count_d + lvl_t'(valid_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      level_q <= level_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      dat_q   <= dat_d;
    end
  end

  assign full_o  = full_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;
  assign dat_o   = dat_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_sdp_fifo32_ctrl.sv
// Directed + random bench for sdp_fifo32_ctrl with a data scoreboard and occupancy model.
module tb_sdp_fifo32_ctrl;

  localparam int WIDTH = 24;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             wr_i = 1'b0;
  logic [WIDTH-1:0] dat_i = '0;
  logic             ready_i = 1'b0;
  logic             full_o, ovf_o, valid_o;
  logic [WIDTH-1:0] dat_o;
  logic [5:0]       level_o;

  sdp_fifo32_ctrl #(.WIDTH(WIDTH), .DELAY(3)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .wr_i    (wr_i),
    .dat_i   (dat_i),
    .full_o  (full_o),
    .ovf_o   (ovf_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .dat_o   (dat_o),
    .level_o (level_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;

  logic [WIDTH-1:0] exp_q [$];
  int               mcnt = 0;
  bit               mv = 1'b0;
  bit               movf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference occupancy model; pushes every accepted word into the scoreboard.
  initial forever begin
    bit acc, ld;
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni || flush_i) begin
      mcnt = 0; mv = 1'b0; movf = 1'b0;
      exp_q.delete();
    end else begin
      ld  = (mcnt != 0) && (!mv || ready_i);
      acc = wr_i && (mcnt != 32);
      if (wr_i && mcnt == 32) movf = 1'b1;
      mcnt = mcnt + int'(acc) - int'(ld);
      if (ld) mv = 1'b1;
      else if (mv && ready_i) mv = 1'b0;
      if (acc) exp_q.push_back(dat_i);
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  initial begin
    bit               stall_q = 1'b0;
    logic [WIDTH-1:0] held_q = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall_q = 1'b0;
      end else begin
        chk("level", 32'(level_o), 32'(mcnt + int'(mv)));
        chk("full",  32'(full_o),  32'(mcnt == 32));
        chk("valid", 32'(valid_o), 32'(mv));
        chk("ovf",   32'(ovf_o),   32'(movf));
        if (stall_q) chk("stall_hold", 32'(dat_o), 32'(held_q));
        if (valid_o && ready_i && !flush_i) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
          end else begin
            chk("data", 32'(dat_o), 32'(exp_q.pop_front()));
            n_xfer++;
          end
        end
        stall_q = valid_o && !ready_i && !flush_i;
        held_q  = dat_o;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    bit gap;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_dat",   32'(dat_o),   32'd0);
    rst_ni = 1'b1;
    tick();

    // Reset mid-stream at level 10
    for (int i = 0; i < 10; i++) begin
      wr_i = 1'b1; dat_i = 24'hA0 + 24'(i); tick();
    end
    wr_i = 1'b0;
    tick(); tick();
    chk("t1_level10", 32'(level_o), 32'd10);
    #2 rst_ni = 1'b0;
    #1;
    chk("t1_level", 32'(level_o), 32'd0);
    chk("t1_valid", 32'(valid_o), 32'd0);
    chk("t1_full",  32'(full_o),  32'd0);
    chk("t1_ovf",   32'(ovf_o),   32'd0);
    chk("t1_dat",   32'(dat_o),   32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Fill: 33 words (one in output register + 32 in RAM), then one overflow write
    for (int i = 1; i <= 33; i++) begin
      wr_i = 1'b1; dat_i = 24'(i); tick();
    end
    wr_i = 1'b0;
    chk("t2_full",  32'(full_o),  32'd1);
    chk("t2_level", 32'(level_o), 32'd33);
    chk("t2_dat",   32'(dat_o),   32'h1);
    chk("t2_ovf0",  32'(ovf_o),   32'd0);
    wr_i = 1'b1; dat_i = 24'h22; tick();
    wr_i = 1'b0;
    chk("t2_ovf1",   32'(ovf_o),   32'd1);
    chk("t2_level2", 32'(level_o), 32'd33);
    ready_i = 1'b1;
    repeat (40) tick();
    ready_i = 1'b0;
    chk("t2_drained", 32'(level_o), 32'd0);
    chk("t2_ovf_sticky", 32'(ovf_o), 32'd1);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    chk("t2_ovf_clr", 32'(ovf_o), 32'd0);

    // Latency: write in cycle n, valid in cycle n+2
    wr_i = 1'b1; dat_i = 24'h5A5A5A; tick();
    wr_i = 1'b0;
    chk("t3_valid_n1", 32'(valid_o), 32'd0);
    tick();
    chk("t3_valid_n2", 32'(valid_o), 32'd1);
    chk("t3_dat",      32'(dat_o),   32'h5A5A5A);
    ready_i = 1'b1; tick(); ready_i = 1'b0; tick();

    // Streaming: 100 words with ready held high
    x0 = n_xfer;
    gap = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_i = 1'b1; dat_i = 24'h100 + 24'(i); tick();
      if (i >= 1 && !valid_o) gap = 1'b1;
    end
    wr_i = 1'b0;
    repeat (3) tick();
    chk("t4_xfers", 32'(n_xfer - x0), 32'd100);
    chk("t4_gap",   32'(gap),         32'd0);
    chk("t4_ovf",   32'(ovf_o),       32'd0);
    chk("t4_level", 32'(level_o),     32'd0);
    ready_i = 1'b0;

    // Flush with write and ready at level 5
    for (int i = 0; i < 5; i++) begin
      wr_i = 1'b1; dat_i = 24'h200 + 24'(i); tick();
    end
    wr_i = 1'b0;
    tick(); tick();
    chk("t5_level5", 32'(level_o), 32'd5);
    flush_i = 1'b1; wr_i = 1'b1; ready_i = 1'b1; dat_i = 24'h2FF; tick();
    flush_i = 1'b0; wr_i = 1'b0; ready_i = 1'b0;
    chk("t5_level", 32'(level_o), 32'd0);
    chk("t5_valid", 32'(valid_o), 32'd0);
    chk("t5_ovf",   32'(ovf_o),   32'd0);
    wr_i = 1'b1; dat_i = 24'h300; tick();
    wr_i = 1'b0;
    chk("t5_valid_n1", 32'(valid_o), 32'd0);
    tick();
    chk("t5_valid_n2", 32'(valid_o), 32'd1);
    chk("t5_dat",      32'(dat_o),   32'h300);
    ready_i = 1'b1; tick(); ready_i = 1'b0;

    // Random traffic against the model and scoreboard
    for (int c = 0; c < 10000; c++) begin
      wr_i    = ($urandom_range(0, 99) < 60);
      ready_i = ($urandom_range(0, 99) < 50);
      flush_i = ($urandom_range(0, 499) == 0);
      dat_i   = WIDTH'($urandom);
      tick();
    end
    wr_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (40) tick();
    chk("t6_empty", 32'(level_o), 32'd0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
